// File: rtl/mul_pkg.sv
// Shared types for the group's sequential multipliers.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mul_state_t;

endpackage

// File: rtl/shift_add_datapath.sv
// Shift-and-add datapath: multiplicand, accumulator and multiplier registers
// with the WIDTH+1-bit adder. It also exposes the post-shift {A,Q} value, so
// the product can be captured on the final iteration edge.
module shift_add_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] aq_next
);

  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   sum;

  // The carry is sum[WIDTH]. It moves into A's MSB in the same step, and a 0
  // always refills C, so no carry flop survives from one iteration to the next.
  always_comb begin
    sum     = {1'b0, a_q} + (q_q[0] ? {1'b0, m_q} : '0);
    aq_next = {sum, q_q[WIDTH-1:1]};
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    if (load) begin
      m_d = a_in;
      q_d = b_in;
      a_d = '0;
    end else if (step) begin
      a_d = sum[WIDTH:1];
      q_d = {sum[0], q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
      a_q <= '0;
      q_q <= '0;
    end else begin
      m_q <= m_d;
      a_q <= a_d;
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one add/shift per clock,
// then a 2*WIDTH-bit product with a one-cycle done strobe.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating, cnt counts completed steps
// DONE  | product valid this cycle; start here is accepted back-to-back
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] aq_next;
  logic               load, step;

  shift_add_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .a_in    (a),
    .b_in    (b),
    .aq_next (aq_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        busy  = 1'b1;
        step  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          product_d = aq_next;
          state_d   = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random bench for shift_add_multiplier with an expected-product queue.
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] product;

  int unsigned exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          n_expect = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one accepted start; operands are scrambled afterwards to prove capture.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(int'(av) * int'(bv));
    n_expect++;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_done(input string tag, output int lat);
    int unsigned e;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_done_seen"}, done, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    if (done === 1'b1) chk({tag, "_product"}, product, e);
  endtask

  initial begin
    int lat;
    int d0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);

    // 13 x 11: latency, busy window, one-cycle done
    start_op(8'd13, 8'd11);
    chk("t1_busy_after_start", busy, 1);
    wait_done("t1", lat);
    chk("t1_latency", lat, W);
    chk("t1_busy_in_done", busy, 0);
    tick();
    chk("t1_done_one_cycle", done, 0);
    chk("t1_product_held", product, 143);

    start_op(8'd255, 8'd255);
    tick(); tick();
    chk("hold_during_next_op", product, 143);
    wait_done("max", lat);
    chk("max_literal", product, 16'hFE01);
    tick();
    start_op(8'd0, 8'd200);
    wait_done("zero_a", lat);
    tick();
    start_op(8'd200, 8'd0);
    wait_done("zero_b", lat);
    tick();

    // start pulsed while busy must be ignored
    d0 = done_cnt;
    start_op(8'd7, 8'd9);
    tick(); tick();
    a = 8'd1; b = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignored_start", lat);
    chk("ignored_product", product, 63);
    repeat (12) tick();
    chk("ignored_single_done", done_cnt - d0, 1);

    // back-to-back: start held across the done cycle
    a = 8'd3; b = 8'd5; start = 1'b1;
    exp_q.push_back(15); n_expect++;
    tick();
    a = 8'd6; b = 8'd7;
    exp_q.push_back(42); n_expect++;
    wait_done("b2b_first", lat);
    chk("b2b_first_latency", lat, 8);
    tick();
    start = 1'b0;
    chk("b2b_reaccepted", busy, 1);
    wait_done("b2b_second", lat);
    chk("b2b_second_at_17", lat + 9, 17);
    tick();

    // reset on the 4th CALC cycle discards the operation
    start_op(8'd100, 8'd100);
    void'(exp_q.pop_back());
    n_expect--;
    tick(); tick(); tick();
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    repeat (12) tick();
    chk("rst_no_done", done_cnt - d0, 0);
    start_op(8'd2, 8'd3);
    wait_done("after_rst", lat);
    tick();

    for (int i = 0; i < 1000; i++) begin
      start_op(W'($urandom), W'($urandom));
      wait_done("rand", lat);
      if ((i % 3) == 0) tick();
    end
    repeat (3) tick();
    chk("total_dones", done_cnt, n_expect);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
